// File: rtl/corr_pkg.sv
// Shared definitions for the correlation peak finder: FSM encoding and default widths.
// Optional lock detector is enabled by defining CORR_PEAK_LOCK_EN.
package corr_pkg;
   localparam int DEF_LAGS    = 256;
   localparam int DEF_POS_W   = 8;
   localparam int DEF_SCORE_W = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SWEEP  = 2'd1,
      REPORT = 2'd2
   } state_t;
endpackage

// File: rtl/corr_max_tracker.sv
// Running maximum score and its lag position.
// Clear has priority over load; ties keep the earlier lag.
module corr_max_tracker #(
   parameter int POS_W   = 8,
   parameter int SCORE_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               i_clear,
   input  logic               i_load_en,
   input  logic               i_first,
   input  logic [POS_W-1:0]   i_lag,
   input  logic [SCORE_W-1:0] i_score,
   output logic [POS_W-1:0]   o_next_pos,
   output logic [SCORE_W-1:0] o_next_score
);
   logic [POS_W-1:0]   r_pos;
   logic [SCORE_W-1:0] r_score;
   logic               w_take;

   // The first sample of a sweep always loads, so an all-zero sweep still reports lag 0.
   assign w_take = i_load_en && (i_first || (i_score > r_score));

   always_comb begin
      o_next_pos   = r_pos;
      o_next_score = r_score;
      if (i_clear) begin
         o_next_pos   = '0;
         o_next_score = '0;
      end else if (w_take) begin
         o_next_pos   = i_lag;
         o_next_score = i_score;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pos   <= '0;
         r_score <= '0;
      end else begin
         r_pos   <= o_next_pos;
         r_score <= o_next_score;
      end
   end
endmodule

// File: rtl/corr_peak_finder.sv
// Tracks the peak correlation score over one lag sweep and reports it with a done pulse.
// Define CORR_PEAK_LOCK_EN to add the lock_thresh input and lock output.
module corr_peak_finder
   import corr_pkg::*;
#(
   parameter int LAGS    = DEF_LAGS,
   parameter int POS_W   = DEF_POS_W,
   parameter int SCORE_W = DEF_SCORE_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               in_valid,
   input  logic [POS_W-1:0]   in_lag,
   input  logic [SCORE_W-1:0] in_score,
`ifdef CORR_PEAK_LOCK_EN
   input  logic [SCORE_W-1:0] lock_thresh,
   output logic               lock,
`endif
   output logic               busy,
   output logic               done,
   output logic               peak_valid,
   output logic [POS_W-1:0]   peak_pos,
   output logic [SCORE_W-1:0] peak_score,
   output logic               err_order
);
   localparam logic [POS_W-1:0] LAST_LAG = POS_W'(LAGS - 1);

   state_t             r_state;
   logic [POS_W-1:0]   r_exp_lag;
   logic               r_busy;
   logic               r_done;
   logic               r_peak_valid;
   logic [POS_W-1:0]   r_peak_pos;
   logic [SCORE_W-1:0] r_peak_score;
   logic               r_err_order;
   logic               w_accept;
   logic [POS_W-1:0]   w_next_pos;
   logic [SCORE_W-1:0] w_next_score;

   // A start in SWEEP discards that cycle's sample.
   assign w_accept = (r_state == SWEEP) && in_valid && !start;

   corr_max_tracker #(
      .POS_W   (POS_W),
      .SCORE_W (SCORE_W)
   ) u_tracker (
      .clk          (clk),
      .reset        (reset),
      .i_clear      (start),
      .i_load_en    (w_accept),
      .i_first      (r_exp_lag == '0),
      .i_lag        (in_lag),
      .i_score      (in_score),
      .o_next_pos   (w_next_pos),
      .o_next_score (w_next_score)
   );

`ifdef CORR_PEAK_LOCK_EN
   logic r_lock;
   always_ff @(posedge clk) begin
      if (reset)
         r_lock <= 1'b0;
      else if (w_accept && (r_exp_lag == LAST_LAG))
         r_lock <= (w_next_score >= lock_thresh);
   end
   assign lock = r_lock;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_exp_lag    <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_peak_valid <= 1'b0;
         r_peak_pos   <= '0;
         r_peak_score <= '0;
         r_err_order  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state     <= SWEEP;
                  r_busy      <= 1'b1;
                  r_exp_lag   <= '0;
                  r_err_order <= 1'b0;
               end
            end
            SWEEP: begin
               if (start) begin
                  r_exp_lag   <= '0;
                  r_err_order <= 1'b0;
               end else if (in_valid) begin
                  r_exp_lag <= r_exp_lag + POS_W'(1);
                  if (in_lag != r_exp_lag)
                     r_err_order <= 1'b1;
                  // Peak registers take the tracker's next value so they are valid during REPORT.
                  if (r_exp_lag == LAST_LAG) begin
                     r_state      <= REPORT;
                     r_busy       <= 1'b0;
                     r_done       <= 1'b1;
                     r_peak_valid <= 1'b1;
                     r_peak_pos   <= w_next_pos;
                     r_peak_score <= w_next_score;
                  end
               end
            end
            REPORT: begin
               if (start) begin
                  r_state     <= SWEEP;
                  r_busy      <= 1'b1;
                  r_exp_lag   <= '0;
                  r_err_order <= 1'b0;
               end else begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy       = r_busy;
   assign done       = r_done;
   assign peak_valid = r_peak_valid;
   assign peak_pos   = r_peak_pos;
   assign peak_score = r_peak_score;
   assign err_order  = r_err_order;
endmodule

// File: tb/tb_corr_peak_finder.sv
// Randomized self-checking bench for corr_peak_finder against a whole-sweep reference model.
// Exercises the lock output when CORR_PEAK_LOCK_EN is defined.
module tb_corr_peak_finder;
   localparam int LAGS    = 256;
   localparam int POS_W   = 8;
   localparam int SCORE_W = 16;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               start = 1'b0;
   logic               in_valid = 1'b0;
   logic [POS_W-1:0]   in_lag = '0;
   logic [SCORE_W-1:0] in_score = '0;
   logic               busy, done, peak_valid, err_order;
   logic [POS_W-1:0]   peak_pos;
   logic [SCORE_W-1:0] peak_score;
`ifdef CORR_PEAK_LOCK_EN
   logic [SCORE_W-1:0] lock_thresh = '0;
   logic               lock;
`endif

   always #5 clk = ~clk;

   corr_peak_finder #(
      .LAGS    (LAGS),
      .POS_W   (POS_W),
      .SCORE_W (SCORE_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .in_valid    (in_valid),
      .in_lag      (in_lag),
      .in_score    (in_score),
`ifdef CORR_PEAK_LOCK_EN
      .lock_thresh (lock_thresh),
      .lock        (lock),
`endif
      .busy        (busy),
      .done        (done),
      .peak_valid  (peak_valid),
      .peak_pos    (peak_pos),
      .peak_score  (peak_score),
      .err_order   (err_order)
   );

   int n_chk = 0;
   int n_fail = 0;
   int done_cnt = 0;
   int prev_pos = 0;
   int prev_score = 0;
   bit have_prev = 0;

   logic [POS_W-1:0]   s_lag   [LAGS];
   logic [SCORE_W-1:0] s_score [LAGS];

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Peak = largest score over the sweep, position = lag of its earliest occurrence.
   task automatic model(output int m_pos, output int m_score, output bit m_err);
      m_score = 0;
      for (int i = 0; i < LAGS; i++)
         if (int'(s_score[i]) > m_score) m_score = int'(s_score[i]);
      m_pos = -1;
      for (int i = 0; i < LAGS; i++)
         if (int'(s_score[i]) == m_score && m_pos < 0) m_pos = int'(s_lag[i]);
      m_err = 0;
      for (int i = 0; i < LAGS; i++)
         if (int'(s_lag[i]) != i) m_err = 1;
   endtask

   task automatic fill_tri();
      for (int i = 0; i < LAGS; i++) begin
         int d;
         d = (i > 64) ? i - 64 : 64 - i;
         s_lag[i]   = POS_W'(i);
         s_score[i] = (d < 128) ? SCORE_W'(128 - d) : '0;
      end
   endtask

   task automatic fill_rand(input int lo, input int hi);
      for (int i = 0; i < LAGS; i++) begin
         s_lag[i]   = POS_W'(i);
         s_score[i] = SCORE_W'($urandom_range(hi, lo));
      end
   endtask

   // One sweep from the current arrays; abort_at >= 0 stops feeding after that many samples.
   task automatic do_sweep(input string name, input int gap_every, input int gap_pct, input int abort_at);
      int i, cyc, busy_low, m_pos, m_score;
      bit m_err;
      start = 1'b1;
      in_valid = 1'b1;
      in_lag = '0;
      in_score = '1;
      @(posedge clk); #1;
      start = 1'b0;
      in_valid = 1'b0;
      chk({name, ".err_clr"}, err_order, 0);
      if (have_prev) begin
         chk({name, ".hold_pos"}, peak_pos, prev_pos);
         chk({name, ".hold_score"}, peak_score, prev_score);
      end
      i = 0; cyc = 0; busy_low = 0;
      while (i < LAGS) begin
         if (abort_at >= 0 && i == abort_at) begin
            in_valid = 1'b0;
            return;
         end
         if (busy !== 1'b1) busy_low++;
         cyc++;
         if ((gap_every > 0 && cyc % gap_every == 0) ||
             (gap_pct > 0 && int'($urandom_range(99)) < gap_pct)) begin
            in_valid = 1'b0;
         end else begin
            in_valid = 1'b1;
            in_lag   = s_lag[i];
            in_score = s_score[i];
            i++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      model(m_pos, m_score, m_err);
      chk({name, ".busy_sweep_low"}, busy_low, 0);
      chk({name, ".done"}, done, 1);
      chk({name, ".peak_valid"}, peak_valid, 1);
      chk({name, ".peak_pos"}, peak_pos, m_pos);
      chk({name, ".peak_score"}, peak_score, m_score);
      chk({name, ".err_order"}, err_order, m_err);
      chk({name, ".busy_report"}, busy, 0);
`ifdef CORR_PEAK_LOCK_EN
      chk({name, ".lock"}, lock, (m_score >= int'(lock_thresh)) ? 1 : 0);
`endif
      @(posedge clk); #1;
      chk({name, ".done_pulse"}, done, 0);
      chk({name, ".busy_idle"}, busy, 0);
      have_prev  = 1;
      prev_pos   = m_pos;
      prev_score = m_score;
   endtask

   initial begin
      int d0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      chk("rst.peak_valid", peak_valid, 0);
      chk("rst.peak_pos", peak_pos, 0);
      chk("rst.peak_score", peak_score, 0);
      chk("rst.err_order", err_order, 0);
`ifdef CORR_PEAK_LOCK_EN
      chk("rst.lock", lock, 0);
`endif

      // Ideal triangular sweep: peak 128 at lag 64.
      fill_tri();
`ifdef CORR_PEAK_LOCK_EN
      lock_thresh = 16'd128;
`endif
      do_sweep("ideal", 0, 0, -1);
      chk("ideal.pos_const", peak_pos, 64);
      chk("ideal.score_const", peak_score, 128);

      fill_tri();
`ifdef CORR_PEAK_LOCK_EN
      lock_thresh = 16'd129;
`endif
      do_sweep("gapped", 3, 0, -1);

      fill_rand(0, 49);
      s_score[10]  = 16'd50;
      s_score[200] = 16'd50;
      do_sweep("tie", 0, 0, -1);
      chk("tie.pos_const", peak_pos, 10);

      fill_rand(0, 1000);
      s_lag[5] = 8'd7;
      do_sweep("order", 0, 0, -1);
      chk("order.err_const", err_order, 1);

      // Restart mid-sweep: first partial sweep carries large scores that must not leak.
      d0 = done_cnt;
      fill_rand(40000, 65535);
      do_sweep("restart_a", 0, 0, 100);
      fill_rand(0, 1000);
      do_sweep("restart_b", 0, 0, -1);
      repeat (2) @(posedge clk);
      #1;
      chk("restart.done_count", done_cnt - d0, 1);

      // Reset mid-sweep.
      fill_rand(0, 5000);
      do_sweep("reset_a", 0, 0, 100);
      d0 = done_cnt;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("mid_rst.busy", busy, 0);
      chk("mid_rst.peak_valid", peak_valid, 0);
      chk("mid_rst.peak_pos", peak_pos, 0);
      chk("mid_rst.peak_score", peak_score, 0);
      chk("mid_rst.err_order", err_order, 0);
      repeat (5) @(posedge clk);
      #1;
      chk("mid_rst.no_done", done_cnt - d0, 0);
      have_prev = 0;

      for (int k = 0; k < 4; k++) begin
         fill_rand(0, int'($urandom_range(65535, 20)));
         if ($urandom_range(1) == 1) s_lag[$urandom_range(LAGS - 1)] = POS_W'($urandom);
`ifdef CORR_PEAK_LOCK_EN
         lock_thresh = SCORE_W'($urandom);
`endif
         do_sweep($sformatf("rand%0d", k), 0, 25, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/corr_peak_finder.md
Name: corr_peak_finder

Overview:
- Downstream stage of the autocorrelation block.
- Consumes one correlation score per lag index, as the lag counter sweeps 0..LAGS-1, and tracks the maximum score and the lag where it occurs.
- At the end of a sweep, it reports the peak position and score with a one-cycle done pulse.
- Replaces the bench-side max search with synthesizable logic.

Parameters:
- LAGS, 256, number of lag positions per sweep (matches autocorrelation SIZE).
- POS_W, 8, lag index width; requires 2**POS_W >= LAGS.
- SCORE_W, 16, unsigned score width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  pulse: clears trackers and begins a sweep.
- in_valid  input  1  in_lag/in_score valid this cycle.
- in_lag  input  POS_W  lag index of the current score.
- in_score  input  SCORE_W  unsigned correlation score.
- busy  output  1  high while in SWEEP.
- done  output  1  one-cycle pulse when a sweep completes.
- peak_valid  output  1  peak_pos/peak_score hold a completed result.
- peak_pos  output  POS_W  lag index of the maximum score.
- peak_score  output  SCORE_W  maximum score.
- err_order  output  1  sticky: a lag arrived out of sequence during the current sweep.

Behaviour:
- Reset values (synchronous reset):
  - state = IDLE.
  - busy = 0, done = 0, peak_valid = 0, err_order = 0.
  - peak_pos = 0, peak_score = 0.
  - Internal expected-lag counter exp_lag = 0, running max = 0, running position = 0.
- State machine: IDLE, SWEEP, REPORT.
- IDLE:
  - in_valid is ignored.
  - start -> SWEEP; on the same edge clear exp_lag, the running max/position and err_order. peak_valid stays as-is.
- SWEEP (busy = 1):
  - Each cycle with in_valid = 1, one sample is accepted.
  - Compare: if in_score > running max (strictly greater), update running max = in_score and running position = in_lag. Ties keep the earliest lag. Lag 0 always loads (initial max 0, use >= for the first sample only).
  - If in_lag != exp_lag, set err_order = 1; the sample is still compared.
  - exp_lag increments by 1 per accepted sample.
  - Accepting the sample with exp_lag == LAGS-1 -> REPORT.
  - in_valid = 0 stalls; no timeout.
  - start during SWEEP restarts: trackers are cleared, the in-flight sample that cycle is discarded, and the FSM stays in SWEEP.
- REPORT (one cycle):
  - done = 1, peak_valid = 1.
  - peak_pos/peak_score are loaded from the running trackers and are visible in this cycle.
  - Next state is IDLE, or SWEEP if start = 1 in this cycle.
- Latency: done is asserted exactly 1 cycle after the final sample is accepted.
- Outputs peak_pos/peak_score/peak_valid hold until the next REPORT or reset. A new sweep does not clear them.
- err_order holds until the next start or reset.
- Reset asserted mid-sweep aborts immediately to reset values; no done is issued.
- Scores are treated as unsigned; no saturation is needed because only comparisons and copies occur.

Optional Feature:
- Macro: CORR_PEAK_LOCK_EN.
- When defined:
  - Adds input lock_thresh [SCORE_W-1:0] and output lock [1].
  - In REPORT, lock is registered as (running max >= lock_thresh) and held with the peak outputs.
  - Reset value of lock is 0.
- When undefined: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package corr_pkg holds:
  - State encoding constants: IDLE = 2'd0, SWEEP = 2'd1, REPORT = 2'd2.
  - Default widths: POS_W = 8, SCORE_W = 16, LAGS = 256.
- One natural sub-module, corr_max_tracker: the running max/position registers with clear, load-enable and strict-greater compare.
- The FSM, lag counter and output registers stay in corr_peak_finder.

Test Plan:
- Ideal sweep: scores equal to the autocorrelation of a 128-ones block vs. the same block shifted by 64 (triangular, peak 128 at lag 64); in_valid held high -> done 256 cycles after the first accept +1, peak_pos = 64, peak_score = 128, err_order = 0.
- Tie: score 50 at lags 10 and 200, all others lower -> peak_pos = 10, peak_score = 50.
- Gapped input: same stream as the ideal sweep with in_valid dropping every 3rd cycle -> identical results; busy stays high throughout.
- Out-of-order lag: lag 5 sent as 7 -> err_order = 1 at done; peak still computed; err_order clears on the next start.
- Restart/reset mid-sweep: start at lag 100 then a full sweep -> a single done with results from the second sweep only. Reset at lag 100 -> all outputs 0, no done.
- With CORR_PEAK_LOCK_EN: lock_thresh = 128 on the ideal sweep -> lock = 1; lock_thresh = 129 -> lock = 0.
